// File: rtl/bids22_bidder_agent.sv
// rtl/bids22_bidder_agent.sv - per-bidder request FIFO, strobe/ack sequencer and round-result tracking
// Optional one-shot auto-retry of "bid not above max" errors: define BIDS22_AUTO_RETRY_EN.
module bids22_bidder_agent #(
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 16,
  parameter int BID_STEP    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_retract,
  input  logic [15:0] req_amt,
  output logic        rsp_valid,
  output logic [1:0]  rsp_err,
  output logic        rsp_timeout,
  output logic        X_bid,
  output logic        X_retract,
  output logic [15:0] X_bidAmt,
  input  logic        X_ack,
  input  logic [1:0]  X_err,
  input  logic [31:0] X_balance,
  input  logic        X_win,
  input  logic        roundOver,
  input  logic [31:0] maxBid,
  output logic [31:0] balance,
  output logic        won,
  output logic [31:0] won_amt,
  output logic [15:0] bids_sent,
  output logic [15:0] bids_ok,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
`ifdef BIDS22_AUTO_RETRY_EN
  localparam bit AUTO_RETRY = 1'b1;
`else
  localparam bit AUTO_RETRY = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nx;

  logic [16:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;

  logic          cur_retract, retried;
  logic [15:0]   cur_amt;
  logic [TW-1:0] timer;
  logic          ack_take, retry_take, timeout_hit;
  logic [32:0]   step_sum;
  logic [15:0]   retry_amt;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign req_ready = !reset && !full;
  assign push      = req_valid && !full;
  assign pop       = (state == IDLE) && !empty;

  assign ack_take    = X_ack && ((state == ISSUE) || (state == WAIT));
  assign retry_take  = AUTO_RETRY && ack_take && !cur_retract && (X_err == 2'b11) && !retried;
  assign timeout_hit = (state == WAIT) && !X_ack && (timer == TW'(ACK_TIMEOUT - 1));

  // Retry amount is sampled from maxBid in the ack cycle and clamped to the 16-bit bid range.
  assign step_sum  = {1'b0, maxBid} + 33'(BID_STEP);
  assign retry_amt = (step_sum > 33'h0FFFF) ? 16'hFFFF : step_sum[15:0];

  assign X_bid     = (state == ISSUE) && !cur_retract;
  assign X_retract = (state == ISSUE) && cur_retract;
  assign X_bidAmt  = cur_amt;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {req_retract, req_amt};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (!empty) state_nx = ISSUE;
      ISSUE, WAIT: begin
        if (ack_take)             state_nx = retry_take ? ISSUE : RESP;
        else if (state == ISSUE)  state_nx = WAIT;
        else if (timeout_hit)     state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cur_retract <= 1'b0;
      cur_amt     <= '0;
      retried     <= 1'b0;
      timer       <= '0;
      rsp_err     <= '0;
      rsp_timeout <= 1'b0;
      balance     <= '0;
      bids_sent   <= '0;
      bids_ok     <= '0;
      won         <= 1'b0;
      won_amt     <= '0;
    end else begin
      state <= state_nx;

      if (pop) begin
        cur_retract <= mem[rd_ptr][16];
        cur_amt     <= mem[rd_ptr][16] ? 16'h0000 : mem[rd_ptr][15:0];
        retried     <= 1'b0;
      end

      if (state == ISSUE)     timer <= '0;
      else if (state == WAIT) timer <= timer + TW'(1);

      if ((state == ISSUE) && !cur_retract && (bids_sent != 16'hFFFF))
        bids_sent <= bids_sent + 16'd1;

      if (ack_take) begin
        balance <= X_balance;
        if (retry_take) begin
          cur_amt <= retry_amt;
          retried <= 1'b1;
        end else begin
          rsp_err     <= X_err;
          rsp_timeout <= 1'b0;
          if (!cur_retract && (X_err == 2'b00) && (bids_ok != 16'hFFFF))
            bids_ok <= bids_ok + 16'd1;
        end
      end else if (timeout_hit) begin
        rsp_err     <= 2'b00;
        rsp_timeout <= 1'b1;
      end

      // Round results are independent of the request sequencer.
      if (roundOver) begin
        won     <= X_win;
        won_amt <= X_win ? maxBid : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_bids22_bidder_agent.sv
// tb/tb_bids22_bidder_agent.sv - table, hand-sequence and random checks of bids22_bidder_agent
module tb_bids22_bidder_agent;

  localparam int ACK_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_retract;
  logic [15:0] req_amt;
  logic        rsp_valid, rsp_timeout;
  logic [1:0]  rsp_err;
  logic        X_bid, X_retract, X_ack, X_win, roundOver;
  logic [15:0] X_bidAmt;
  logic [1:0]  X_err;
  logic [31:0] X_balance, maxBid, balance, won_amt;
  logic        won, busy;
  logic [15:0] bids_sent, bids_ok;

  bids22_bidder_agent #(.FIFO_DEPTH(4), .ACK_TIMEOUT(ACK_TIMEOUT), .BID_STEP(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_retract(req_retract), .req_amt(req_amt),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .X_bid(X_bid), .X_retract(X_retract), .X_bidAmt(X_bidAmt),
    .X_ack(X_ack), .X_err(X_err), .X_balance(X_balance), .X_win(X_win),
    .roundOver(roundOver), .maxBid(maxBid),
    .balance(balance), .won(won), .won_amt(won_amt),
    .bids_sent(bids_sent), .bids_ok(bids_ok), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int exp_sent = 0;
  int exp_ok = 0;
  logic [31:0] exp_bal = 0;

  typedef struct {
    logic        r;
    logic [15:0] amt;
    int          dly;
    logic [1:0]  err;
    logic [31:0] bal;
    int          lat;
    logic        to;
    logic [1:0]  exp_err;
  } vec_t;

  typedef struct {
    logic        win;
    logic [31:0] mb;
    logic        w;
    logic [31:0] wa;
  } ro_t;

  vec_t tbl[6];
  ro_t  ro_tbl[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_one(input logic r, input logic [15:0] amt);
    int n = 0;
    req_valid = 1'b1; req_retract = r; req_amt = amt;
    while (!req_ready && n < 60) begin tick(); n++; end
    check("push_ready", {31'b0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    while (!(X_bid || X_retract) && n < 60) begin tick(); n++; end
    check("strobe_seen", {31'b0, X_bid || X_retract}, 32'd1);
  endtask

  // Called in the cycle of the strobe (or later); acks after dly ticks, returns ticks until rsp_valid.
  task automatic respond(input int dly, input logic [1:0] err, input logic [31:0] bal, output int lat);
    lat = 0;
    X_err = err; X_balance = bal;
    while (!rsp_valid && lat < 40) begin
      X_ack = (lat == dly);
      tick();
      X_ack = 1'b0;
      lat++;
    end
    check("rsp_seen", {31'b0, rsp_valid}, 32'd1);
  endtask

  task automatic run_txn(input logic r, input logic [15:0] amt, input int dly, input logic [1:0] err,
                         input logic [31:0] bal, input int exp_lat, input logic exp_to,
                         input logic [1:0] exp_err);
    int n, lat;
    push_one(r, amt);
    wait_strobe(n);
    check("strobe_latency", n, 1);
    check("x_bid", {31'b0, X_bid}, {31'b0, !r});
    check("x_retract", {31'b0, X_retract}, {31'b0, r});
    check("x_bidamt", {16'b0, X_bidAmt}, r ? 32'h0 : {16'b0, amt});
    if (!r) exp_sent++;
    respond(dly, err, bal, lat);
    if (!exp_to) exp_bal = bal;
    if (!r && !exp_to && err == 2'b00) exp_ok++;
    check("rsp_latency", lat, exp_lat);
    check("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, exp_to});
    check("rsp_err", {30'b0, rsp_err}, {30'b0, exp_err});
    check("balance", balance, exp_bal);
    check("bids_sent", {16'b0, bids_sent}, exp_sent);
    check("bids_ok", {16'b0, bids_ok}, exp_ok);
    tick();
    check("rsp_one_cycle", {31'b0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int n, lat, bad;
    logic r;
    logic [15:0] amt;
    logic [1:0] err;
    logic [31:0] bal;
    int dly, e_lat;
    logic e_to;

    tbl[0] = '{1'b0, 16'h0064,   3, 2'b00, 32'h0000_03E8,  4, 1'b0, 2'b00};
    tbl[1] = '{1'b1, 16'h1234,   0, 2'b01, 32'h0000_0100,  1, 1'b0, 2'b01};
    tbl[2] = '{1'b0, 16'hFFFF,  16, 2'b10, 32'h0000_0055, 17, 1'b0, 2'b10};
    tbl[3] = '{1'b0, 16'h0001, 255, 2'b01, 32'h0000_0999, 17, 1'b1, 2'b00};
    tbl[4] = '{1'b0, 16'h8000,  15, 2'b00, 32'hDEAD_BEEF, 16, 1'b0, 2'b00};
    tbl[5] = '{1'b1, 16'h4444, 255, 2'b10, 32'h0000_0777, 17, 1'b1, 2'b00};
    ro_tbl[0] = '{1'b1, 32'h0000_01F4, 1'b1, 32'h0000_01F4};
    ro_tbl[1] = '{1'b0, 32'h0000_0300, 1'b0, 32'h0000_0000};
    ro_tbl[2] = '{1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF};

    reset = 1'b1; req_valid = 0; req_retract = 0; req_amt = 0;
    X_ack = 0; X_err = 0; X_balance = 0; X_win = 0; roundOver = 0; maxBid = 0;
    tick(); tick();
    check("reset_req_ready", {31'b0, req_ready}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset_x_bid", {31'b0, X_bid}, 32'd0);
    check("reset_balance", balance, 32'd0);
    check("reset_bids_sent", {16'b0, bids_sent}, 32'd0);
    reset = 1'b0;
    tick();
    check("idle_req_ready", {31'b0, req_ready}, 32'd1);
    check("idle_busy", {31'b0, busy}, 32'd0);

    for (int i = 0; i < 6; i++)
      run_txn(tbl[i].r, tbl[i].amt, tbl[i].dly, tbl[i].err, tbl[i].bal, tbl[i].lat, tbl[i].to, tbl[i].exp_err);

    // FIFO fill while one bid is outstanding, then drain in order.
    push_one(1'b0, 16'h00A0);
    wait_strobe(n);
    exp_sent++;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_retract = 1'b0; req_amt = 16'h00B0 + 16'(i);
      check("fill_ready", {31'b0, req_ready}, (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) tick();
    end
    X_ack = 1'b1; X_err = 2'b00; X_balance = 32'h111;
    tick();
    X_ack = 1'b0;
    exp_ok++; exp_bal = 32'h111;
    check("fill_rsp", {31'b0, rsp_valid}, 32'd1);
    n = 0;
    while (!req_ready && n < 10) begin tick(); n++; end
    check("ready_return_delay", n, 2);
    check("fill_head_bid", {31'b0, X_bid}, 32'd1);
    check("fill_head_amt", {16'b0, X_bidAmt}, 32'h00B0);
    exp_sent++;
    tick();
    req_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      respond(0, 2'b00, 32'h111, lat);
      exp_ok++;
      check("drain_rsp_latency", lat, 1);
      if (j < 4) begin
        wait_strobe(n);
        exp_sent++;
        check("drain_issue_gap", n, 2);
        check("drain_order", {16'b0, X_bidAmt}, 32'h00B0 + 32'(j + 1));
      end
    end
    check("drain_bids_sent", {16'b0, bids_sent}, exp_sent);
    check("drain_bids_ok", {16'b0, bids_ok}, exp_ok);
    tick();

    // Timeout on the first of two queued bids; the second issues two cycles after the response.
    push_one(1'b0, 16'h00C1);
    push_one(1'b0, 16'h00C2);
    wait_strobe(n);
    exp_sent++;
    check("chain_first_amt", {16'b0, X_bidAmt}, 32'h00C1);
    respond(255, 2'b00, 32'h0, lat);
    check("chain_timeout_latency", lat, ACK_TIMEOUT + 1);
    check("chain_timeout_flag", {31'b0, rsp_timeout}, 32'd1);
    check("chain_balance_held", balance, exp_bal);
    wait_strobe(n);
    exp_sent++;
    check("chain_next_gap", n, 2);
    check("chain_next_amt", {16'b0, X_bidAmt}, 32'h00C2);
    respond(0, 2'b00, 32'h123, lat);
    exp_ok++; exp_bal = 32'h123;
    check("chain_next_timeout", {31'b0, rsp_timeout}, 32'd0);
    tick();

    for (int i = 0; i < 3; i++) begin
      roundOver = 1'b1; X_win = ro_tbl[i].win; maxBid = ro_tbl[i].mb;
      tick();
      roundOver = 1'b0; X_win = ~ro_tbl[i].win; maxBid = 32'h5A5A;
      check("round_won", {31'b0, won}, {31'b0, ro_tbl[i].w});
      check("round_won_amt", won_amt, ro_tbl[i].wa);
      tick();
      check("round_hold", {31'b0, won}, {31'b0, ro_tbl[i].w});
    end
    X_win = 1'b0; maxBid = 0;

    // Auto-retry on err 11 (feature build) vs direct error report (default build).
    push_one(1'b0, 16'h0050);
    wait_strobe(n);
    exp_sent++;
    maxBid = 32'h0000_00C8;
    tick();
    X_ack = 1'b1; X_err = 2'b11; X_balance = 32'h222;
    tick();
    X_ack = 1'b0;
    exp_bal = 32'h222;
`ifdef BIDS22_AUTO_RETRY_EN
    check("retry_no_rsp", {31'b0, rsp_valid}, 32'd0);
    check("retry_bid", {31'b0, X_bid}, 32'd1);
    check("retry_amt", {16'b0, X_bidAmt}, 32'h00C9);
    exp_sent++;
    respond(1, 2'b00, 32'h333, lat);
    exp_ok++; exp_bal = 32'h333;
    check("retry_rsp_latency", lat, 2);
    check("retry_rsp_err", {30'b0, rsp_err}, 32'd0);
`else
    check("noretry_rsp", {31'b0, rsp_valid}, 32'd1);
    check("noretry_rsp_err", {30'b0, rsp_err}, 32'd3);
`endif
    check("retry_bids_sent", {16'b0, bids_sent}, exp_sent);
    check("retry_bids_ok", {16'b0, bids_ok}, exp_ok);
    check("retry_balance", balance, exp_bal);
    maxBid = 0;
    tick();

    // Random requests against the rule-level reference.
    for (int k = 0; k < 40; k++) begin
      r   = ($urandom_range(0, 3) == 0);
      amt = 16'($urandom);
      dly = $urandom_range(0, 20);
      err = 2'($urandom_range(0, 2));
      bal = $urandom;
      e_to  = (dly > ACK_TIMEOUT);
      e_lat = e_to ? ACK_TIMEOUT + 1 : dly + 1;
      run_txn(r, amt, dly, err, bal, e_lat, e_to, e_to ? 2'b00 : err);
    end

    // Reset while a bid is outstanding and another is queued.
    push_one(1'b0, 16'h00D0);
    push_one(1'b0, 16'h00D1);
    tick(); tick();
    reset = 1'b1;
    #1;
    check("midreset_busy", {31'b0, busy}, 32'd0);
    check("midreset_rsp", {31'b0, rsp_valid}, 32'd0);
    check("midreset_bids_sent", {16'b0, bids_sent}, 32'd0);
    check("midreset_bidamt", {16'b0, X_bidAmt}, 32'd0);
    tick();
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rsp_valid || X_bid || X_retract || busy) bad++;
    end
    check("post_reset_quiet", bad, 0);
    check("post_reset_ready", {31'b0, req_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
